// File: rtl/connect_n_pkg.sv
// Shared encodings for the Connect-N board engine: cell/win codes, FSM states
// and the (column, row) step of each of the four scan directions.
package connect_n_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    PLACE,
    SCAN0,
    SCAN1,
    SCAN2,
    SCAN3,
    DONE
  } state_t;

  // Scan order: horizontal, vertical, diagonal /, diagonal \.
  localparam int DIR_DC [4] = '{1, 0, 1, 1};
  localparam int DIR_DR [4] = '{0, 1, 1, -1};

endpackage

// File: rtl/connect_n_board_engine_cursor.sv
// Wrap-around column cursor; moves only while enabled, opposing pulses cancel.
module column_cursor
  import connect_n_pkg::*;
#(
  parameter int COLS  = 7,
  parameter int COL_W = $clog2(COLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             left,
  input  logic             right,
  output logic [COL_W-1:0] sel_col
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_col <= '0;
    end else if (en && right && !left) begin
      sel_col <= (sel_col == COL_W'(COLS - 1)) ? '0 : sel_col + 1'b1;
    end else if (en && left && !right) begin
      sel_col <= (sel_col == '0) ? COL_W'(COLS - 1) : sel_col - 1'b1;
    end
  end

endmodule

// File: rtl/connect_n_board_engine.sv
// Connect-N core: cursor, gravity-drop board, 4-cycle win scan, draw detect.
// Optional AUTO_TURN_EN: piece colour from an internal turn bit instead of player_colour.
module connect_n_board_engine
  import connect_n_pkg::*;
#(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4,
  parameter int COL_W   = $clog2(COLS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     right,
  input  logic                     left,
  input  logic                     drop,
  input  logic                     player_colour,
  output logic [COL_W-1:0]         sel_col,
  output logic [2*ROWS*COLS-1:0]   board,
  output logic                     busy,
  output logic                     illegal,
  output logic [1:0]               win,
  output logic                     draw
);

  localparam int CELLS = ROWS * COLS;
  localparam int H_W   = $clog2(ROWS + 1);
  localparam int CNT_W = $clog2(CELLS + 1);

  state_t           state, state_nxt;
  logic [H_W-1:0]   heights [COLS];
  logic [CNT_W-1:0] pieces;
  logic [COL_W-1:0] col_q;
  logic [H_W-1:0]   row_q;
  logic [1:0]       code_q;
  logic             hit_q, hit_now;
  logic             idle, col_full, accept, reject, colour_now;
  int               k, pos_run, neg_run;
  logic             pos_go, neg_go;

`ifdef AUTO_TURN_EN
  logic turn_q;
  assign colour_now = turn_q;
`else
  assign colour_now = player_colour;
`endif

  assign idle     = (state == IDLE);
  assign col_full = (heights[sel_col] == H_W'(ROWS));
  assign accept   = idle && drop && !col_full;
  assign reject   = idle && drop && col_full;
  assign busy     = (state != IDLE) && (state != DONE);

  column_cursor #(.COLS(COLS), .COL_W(COL_W)) u_cursor (
    .clk     (clk),
    .reset   (reset),
    .en      (idle),
    .left    (left),
    .right   (right),
    .sel_col (sel_col)
  );

  function automatic logic [1:0] cell_at(input logic [2*CELLS-1:0] b, input int c, input int r);
    if (c < 0 || c >= COLS || r < 0 || r >= ROWS) return CELL_EMPTY;
    return b[2*(c*ROWS+r) +: 2];
  endfunction

  // Run length through the placed piece along the direction of the current scan state.
  always_comb begin
    k       = 0;
    pos_run = 0;
    neg_run = 0;
    pos_go  = 1'b1;
    neg_go  = 1'b1;
    case (state)
      SCAN1:   k = 1;
      SCAN2:   k = 2;
      SCAN3:   k = 3;
      default: k = 0;
    endcase
    for (int i = 1; i < WIN_LEN; i++) begin
      if (pos_go && cell_at(board, int'(col_q) + i*DIR_DC[k], int'(row_q) + i*DIR_DR[k]) == code_q)
        pos_run = pos_run + 1;
      else
        pos_go = 1'b0;
      if (neg_go && cell_at(board, int'(col_q) - i*DIR_DC[k], int'(row_q) - i*DIR_DR[k]) == code_q)
        neg_run = neg_run + 1;
      else
        neg_go = 1'b0;
    end
    hit_now = ((1 + pos_run + neg_run) >= WIN_LEN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = PLACE;
      PLACE:   state_nxt = SCAN0;
      SCAN0:   state_nxt = SCAN1;
      SCAN1:   state_nxt = SCAN2;
      SCAN2:   state_nxt = SCAN3;
      SCAN3:   state_nxt = (hit_q || hit_now || pieces == CNT_W'(CELLS)) ? DONE : IDLE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      board   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      code_q  <= CELL_EMPTY;
      hit_q   <= 1'b0;
      pieces  <= '0;
      illegal <= 1'b0;
      win     <= WIN_NONE;
      draw    <= 1'b0;
      for (int c = 0; c < COLS; c++) heights[c] <= '0;
`ifdef AUTO_TURN_EN
      turn_q  <= 1'b0;
`endif
    end else begin
      illegal <= reject;
      case (state)
        IDLE: if (accept) begin
          col_q  <= sel_col;
          row_q  <= heights[sel_col];
          code_q <= colour_now ? CELL_P2 : CELL_P1;
          hit_q  <= 1'b0;
        end
        PLACE: begin
          board[2*(int'(col_q)*ROWS + int'(row_q)) +: 2] <= code_q;
          heights[col_q] <= heights[col_q] + 1'b1;
          pieces         <= pieces + 1'b1;
        end
        SCAN0, SCAN1, SCAN2: if (hit_now) hit_q <= 1'b1;
        SCAN3: begin
          if (hit_q || hit_now) win <= code_q;
          else if (pieces == CNT_W'(CELLS)) draw <= 1'b1;
`ifdef AUTO_TURN_EN
          else turn_q <= ~turn_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_connect_n_board_engine.sv
// Self-checking bench for connect_n_board_engine: cursor vector table, directed
// game sequences, and random games against a whole-board reference model.
module tb_connect_n_board_engine;

  localparam int ROWS    = 6;
  localparam int COLS    = 7;
  localparam int WIN_LEN = 4;
  localparam int COL_W   = $clog2(COLS);
  localparam int NB      = 2 * ROWS * COLS;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             right = 1'b0, left = 1'b0, drop = 1'b0, player_colour = 1'b0;
  logic [COL_W-1:0] sel_col;
  logic [NB-1:0]    board;
  logic             busy, illegal, draw;
  logic [1:0]       win;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain 2-D board plus bookkeeping
  int m_cell [COLS][ROWS];
  int m_h    [COLS];
  int m_sel, m_win, m_count;
  bit m_draw, m_done, m_turn;
  logic [NB-1:0] exp_q[$];

  typedef struct { bit r; bit l; int exp; } cur_vec_t;
  cur_vec_t cv [10];

  // Move encoding: column*2 + player (0 = P1, 1 = P2)
  int seq_h  [7]  = '{0, 13, 2, 13, 4, 13, 6};
  int seq_d1 [10] = '{1, 2, 3, 4, 4, 5, 6, 6, 6, 7};
  int seq_d2 [10] = '{7, 4, 5, 2, 2, 3, 0, 0, 0, 1};

  connect_n_board_engine #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN)) dut (
    .clk           (clk),
    .reset         (reset),
    .right         (right),
    .left          (left),
    .drop          (drop),
    .player_colour (player_colour),
    .sel_col       (sel_col),
    .board         (board),
    .busy          (busy),
    .illegal       (illegal),
    .win           (win),
    .draw          (draw)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] model_board();
    logic [NB-1:0] v;
    v = '0;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        v[2*(c*ROWS+r) +: 2] = 2'(m_cell[c][r]);
    return v;
  endfunction

  // Any WIN_LEN window of identical non-empty cells anywhere on the board
  function automatic int model_winner();
    int dc [4] = '{1, 0, 1, 1};
    int dr [4] = '{0, 1, 1, -1};
    int n, cc, rr;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        for (int d = 0; d < 4; d++) begin
          if (m_cell[c][r] == 0) continue;
          n = 0;
          for (int i = 0; i < WIN_LEN; i++) begin
            cc = c + i*dc[d];
            rr = r + i*dr[d];
            if (cc >= 0 && cc < COLS && rr >= 0 && rr < ROWS && m_cell[cc][rr] == m_cell[c][r]) n++;
          end
          if (n == WIN_LEN) return m_cell[c][r];
        end
    return 0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < COLS; c++) begin
      m_h[c] = 0;
      for (int r = 0; r < ROWS; r++) m_cell[c][r] = 0;
    end
    m_sel = 0; m_win = 0; m_count = 0; m_draw = 0; m_done = 0; m_turn = 0;
  endtask

  task automatic do_reset();
    right = 0; left = 0; drop = 0;
    reset = 1'b0;
    #1;
    check("rst_board", board, '0);
    check("rst_win", win, 2'b00);
    check("rst_draw", draw, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    check("rst_sel", sel_col, '0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Drive one cycle of inputs at a falling edge; returns at the next falling edge
  task automatic step(input bit r, input bit l, input bit d, input bit c);
    right = r; left = l; drop = d; player_colour = c;
    @(negedge clk);
    right = 0; left = 0; drop = 0;
  endtask

  task automatic move_to(input int col);
    while (m_sel != col) begin
      step(1, 0, 0, 0);
      m_sel = (m_sel + 1) % COLS;
      check("cursor_move", sel_col, m_sel);
    end
  endtask

  task automatic drop_piece(input int col, input bit colour, input bit mv);
    int w;
    int code;
    if (!m_done) move_to(col);
    if (m_done) begin
      step(mv, 0, 1, colour);
      check("done_busy", busy, 1'b0);
      check("done_sel", sel_col, m_sel);
      repeat (6) @(negedge clk);
      check("done_board", board, model_board());
      check("done_win", win, m_win);
      check("done_draw", draw, m_draw);
      return;
    end
    if (m_h[col] == ROWS) begin
      step(mv, 0, 1, colour);
      if (mv) m_sel = (m_sel + 1) % COLS;
      check("illegal_pulse", illegal, 1'b1);
      check("illegal_busy", busy, 1'b0);
      check("illegal_sel", sel_col, m_sel);
      @(negedge clk);
      check("illegal_clear", illegal, 1'b0);
      check("illegal_board", board, model_board());
      return;
    end
`ifdef AUTO_TURN_EN
    code = m_turn ? 2 : 1;
`else
    code = colour ? 2 : 1;
`endif
    exp_q.push_back(model_board());
    m_cell[col][m_h[col]] = code;
    m_h[col]++;
    m_count++;
    exp_q.push_back(model_board());
    step(mv, 0, 1, colour);
    if (mv) m_sel = (m_sel + 1) % COLS;
    check("drop_sel", sel_col, m_sel);
    check("place_busy", busy, 1'b1);
    check("place_board_old", board, exp_q.pop_front());
    @(negedge clk);
    check("place_board_new", board, exp_q.pop_front());
    repeat (3) @(negedge clk);
    check("scan3_busy", busy, 1'b1);
    check("scan3_win", win, m_win);
    @(negedge clk);
    w = model_winner();
    if (w != 0) begin
      m_win = w; m_done = 1;
    end else if (m_count == ROWS*COLS) begin
      m_draw = 1; m_done = 1;
    end else begin
      m_turn = ~m_turn;
    end
    check("end_busy", busy, 1'b0);
    check("end_win", win, m_win);
    check("end_draw", draw, m_draw);
  endtask

  initial begin
    logic [11:0] col2;
    @(negedge clk);
    do_reset();

    // Cursor table: 3 rights, 5 lefts (wrapping through 0), both, neither
    cv = '{'{1, 0, 1}, '{1, 0, 2}, '{1, 0, 3}, '{0, 1, 2}, '{0, 1, 1},
           '{0, 1, 0}, '{0, 1, 6}, '{0, 1, 5}, '{1, 1, 5}, '{0, 0, 5}};
    for (int i = 0; i < 10; i++) begin
      step(cv[i].r, cv[i].l, 0, 0);
      check("cursor_tbl", sel_col, cv[i].exp);
      m_sel = cv[i].exp;
    end

    // Fill column 2 with alternating colours, then one drop too many
    for (int i = 0; i < 7; i++) drop_piece(2, i[0], 0);
    col2 = board[2*(2*ROWS) +: 12];
    check("col2_pattern", col2, 12'h999);

    // Horizontal P1 win, then ignored inputs
    do_reset();
    foreach (seq_h[i]) drop_piece(seq_h[i] / 2, seq_h[i][0], 0);
`ifndef AUTO_TURN_EN
    check("hwin_code", win, 2'b01);
`endif
    drop_piece(4, 0, 1);
    step(1, 0, 0, 0);
    check("done_cursor_frozen", sel_col, m_sel);

    // Diagonal wins for P2
    do_reset();
    foreach (seq_d1[i]) drop_piece(seq_d1[i] / 2, seq_d1[i][0], 0);
`ifndef AUTO_TURN_EN
    check("diag1_win", win, 2'b10);
`endif
    do_reset();
    foreach (seq_d2[i]) drop_piece(seq_d2[i] / 2, seq_d2[i][0], 0);
`ifndef AUTO_TURN_EN
    check("diag2_win", win, 2'b10);
`endif

    // Full board with no four-in-a-row
    do_reset();
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        drop_piece(c, 1'(((r >> 1) + c) & 1), 0);
`ifndef AUTO_TURN_EN
    check("draw_flag", draw, 1'b1);
    check("draw_nowin", win, 2'b00);
`endif
    drop_piece(0, 0, 0);

    // Commands while busy are dropped; reset during SCAN1 clears everything
    do_reset();
    move_to(4);
    step(0, 0, 1, 0);
    step(1, 0, 1, 1);
    step(0, 1, 1, 1);
    repeat (3) @(negedge clk);
    m_cell[4][0] = 1; m_h[4] = 1; m_count = 1; m_turn = 1;
    check("busy_ignored_board", board, model_board());
    check("busy_ignored_sel", sel_col, 4);
    check("busy_ignored_busy", busy, 1'b0);
    step(0, 0, 1, 1);
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Random games against the model
    for (int g = 0; g < 4; g++) begin
      do_reset();
      repeat (40) drop_piece($urandom_range(0, COLS - 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
